// File: rtl/ram_arb_pkg.sv
// Shared helpers and types for ram_access_arbiter and its round-robin arbiters.
package ram_arb_pkg;

   // Largest requester count the arbiter supports; index type sized to match.
   localparam int MAX_NREQ = 4;
   typedef logic [$clog2(MAX_NREQ)-1:0] req_idx_t;

   // $clog2 that never returns 0, so single-entry configurations still get a 1-bit field.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Round-robin pointer advance: the slot after the winner, wrapping at n.
   function automatic int ptr_next(input int g, input int n);
      return (g + 1 >= n) ? 0 : g + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans req starting at ptr, wrapping modulo N,
// and grants the first asserted request. Grant is one-hot or zero.
module rr_arbiter
   import ram_arb_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = clog2_min1(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   int   idx;
   logic found;

   // Priority scan from ptr; the first hit stops further grants.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_idx  = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares one simple dual-port RAM (1 write, 1 registered read) between NREQ clients
// with independent round-robin arbitration on each port. Read data returns one cycle
// after the grant, tagged with the requester index.
// Optional build macro WR_FWD_EN: same-cycle write/read to one address returns the
// new data (write-first); without it the RAM's old contents are returned (read-first).
module ram_access_arbiter
   import ram_arb_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int NREQ  = 2,
   localparam int AW   = clog2_min1(DEPTH),
   localparam int IW   = clog2_min1(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       wr_req,
   input  logic [NREQ*AW-1:0]    wr_addr,
   input  logic [NREQ*WIDTH-1:0] wr_data,
   output logic [NREQ-1:0]       wr_gnt,
   input  logic [NREQ-1:0]       rd_req,
   input  logic [NREQ*AW-1:0]    rd_addr,
   output logic [NREQ-1:0]       rd_gnt,
   output logic                  rd_valid,
   output logic [IW-1:0]         rd_id,
   output logic [WIDTH-1:0]      rd_data,
   output logic                  ram_we,
   output logic [AW-1:0]         ram_wr_addr,
   output logic [WIDTH-1:0]      ram_din,
   output logic                  ram_re,
   output logic [AW-1:0]         ram_rd_addr,
   input  logic [WIDTH-1:0]      ram_dout
);

   logic [IW-1:0]   wr_ptr, rd_ptr;
   logic [IW-1:0]   wr_idx, rd_idx;
   logic [NREQ-1:0] wr_req_m, rd_req_m;

   // Reset masks requests so no grant or RAM strobe can escape while rst is high.
   assign wr_req_m = rst ? '0 : wr_req;
   assign rd_req_m = rst ? '0 : rd_req;

   rr_arbiter #(.N(NREQ), .IW(IW)) u_wr_arb (
      .req     (wr_req_m),
      .ptr     (wr_ptr),
      .gnt     (wr_gnt),
      .gnt_idx (wr_idx)
   );

   rr_arbiter #(.N(NREQ), .IW(IW)) u_rd_arb (
      .req     (rd_req_m),
      .ptr     (rd_ptr),
      .gnt     (rd_gnt),
      .gnt_idx (rd_idx)
   );

   // RAM-side muxing from the winning requester; addresses pass through unchecked.
   assign ram_we      = |wr_gnt;
   assign ram_wr_addr = wr_addr[wr_idx*AW +: AW];
   assign ram_din     = wr_data[wr_idx*WIDTH +: WIDTH];
   assign ram_re      = |rd_gnt;
   assign ram_rd_addr = rd_addr[rd_idx*AW +: AW];

   // Round-robin pointers: advance past the winner, hold when the port is idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (ram_we) wr_ptr <= IW'(ptr_next(int'(wr_idx), NREQ));
         if (ram_re) rd_ptr <= IW'(ptr_next(int'(rd_idx), NREQ));
      end
   end

   // Read return tag: valid and owner one cycle after the grant; reset drops in-flight reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid <= 1'b0;
         rd_id    <= '0;
      end else begin
         rd_valid <= ram_re;
         if (ram_re) rd_id <= rd_idx;
      end
   end

`ifdef WR_FWD_EN
   logic             fwd_vld;
   logic [WIDTH-1:0] fwd_data;

   // Capture write data when it collides with the read address so the read sees it.
   always_ff @(posedge clk) begin
      if (rst) begin
         fwd_vld  <= 1'b0;
         fwd_data <= '0;
      end else begin
         fwd_vld <= ram_we && ram_re && (ram_wr_addr == ram_rd_addr);
         if (ram_we && ram_re && (ram_wr_addr == ram_rd_addr)) fwd_data <= ram_din;
      end
   end

   assign rd_data = fwd_vld ? fwd_data : ram_dout;
`else
   assign rd_data = ram_dout;
`endif

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Bench for ram_access_arbiter: RAM model, directed table, hand sequences for
// same-cycle RAW and mid-flight reset, then randomized traffic against a reference model.
module tb_ram_access_arbiter;

   localparam int WIDTH = 8;
   localparam int DEPTH = 8;
   localparam int NREQ  = 2;
   localparam int AW    = 3;
   localparam int IW    = 1;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       wr_req, wr_gnt, rd_req, rd_gnt;
   logic [NREQ*AW-1:0]    wr_addr, rd_addr;
   logic [NREQ*WIDTH-1:0] wr_data;
   logic                  rd_valid;
   logic [IW-1:0]         rd_id;
   logic [WIDTH-1:0]      rd_data;
   logic                  ram_we, ram_re;
   logic [AW-1:0]         ram_wr_addr, ram_rd_addr;
   logic [WIDTH-1:0]      ram_din, ram_dout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ram_access_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
      .clk(clk), .rst(rst),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
      .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data),
      .ram_we(ram_we), .ram_wr_addr(ram_wr_addr), .ram_din(ram_din),
      .ram_re(ram_re), .ram_rd_addr(ram_rd_addr), .ram_dout(ram_dout)
   );

   // Simple dual-port RAM with registered, read-first output.
   logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};
   always @(posedge clk) begin
      if (ram_re) ram_dout <= mem[ram_rd_addr];
      if (ram_we) mem[ram_wr_addr] <= ram_din;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference round-robin: first asserted request at or after ptr, modulo NREQ.
   function automatic int arb(input logic [NREQ-1:0] req, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         if (req[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return -1;
   endfunction

   typedef struct {
      logic       rst;
      logic [1:0] wr, rd, wg, rg;
      logic       rv;
      logic [0:0] rid;
      logic [7:0] rdata;
   } vec_t;

   vec_t tbl[10];

   // Reference-model state for the random phase.
   logic [WIDTH-1:0] shadow [DEPTH];
   int               m_wptr, m_rptr, wi, ri;
   logic             m_rv;
   logic [IW-1:0]    m_rid;
   logic [WIDTH-1:0] m_rdata;
   logic [NREQ-1:0]  e_wg, e_rg;
   logic [AW-1:0]    wa, ra;
   logic [WIDTH-1:0] wd;

   initial begin
      // rst, wr_req, rd_req, exp wr_gnt, exp rd_gnt, exp rd_valid, exp rd_id, exp rd_data
      tbl[0] = '{1'b1, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00};
      tbl[1] = '{1'b1, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00};
      tbl[2] = '{1'b0, 2'b11, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 8'h00};
      tbl[3] = '{1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 8'h00};
      tbl[4] = '{1'b0, 2'b00, 2'b11, 2'b00, 2'b01, 1'b0, 1'b0, 8'h00};
      tbl[5] = '{1'b0, 2'b00, 2'b11, 2'b00, 2'b10, 1'b1, 1'b0, 8'hA5};
      tbl[6] = '{1'b0, 2'b00, 2'b11, 2'b00, 2'b01, 1'b1, 1'b1, 8'h5A};
      tbl[7] = '{1'b0, 2'b00, 2'b11, 2'b00, 2'b10, 1'b1, 1'b0, 8'hA5};
      tbl[8] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 8'h5A};
      tbl[9] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00};

      rst     = 1'b1;
      wr_req  = '1;
      rd_req  = '1;
      wr_addr = {3'd4, 3'd3};
      wr_data = {8'h5A, 8'hA5};
      rd_addr = {3'd4, 3'd3};

      // Directed table: reset, write contention, read fairness, read return.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         rst    = tbl[i].rst;
         wr_req = tbl[i].wr;
         rd_req = tbl[i].rd;
         #2;
         chk($sformatf("tbl%0d_wr_gnt", i), 32'(wr_gnt), 32'(tbl[i].wg));
         chk($sformatf("tbl%0d_rd_gnt", i), 32'(rd_gnt), 32'(tbl[i].rg));
         chk($sformatf("tbl%0d_rd_valid", i), 32'(rd_valid), 32'(tbl[i].rv));
         if (tbl[i].rv || tbl[i].rst)
            chk($sformatf("tbl%0d_rd_id", i), 32'(rd_id), 32'(tbl[i].rid));
         if (tbl[i].rv)
            chk($sformatf("tbl%0d_rd_data", i), 32'(rd_data), 32'(tbl[i].rdata));
      end
      chk("mem3", 32'(mem[3]), 32'h A5);
      chk("mem4", 32'(mem[4]), 32'h 5A);

      // Same-cycle write and read of address 3 (both pointers are at 0 here).
      @(negedge clk);
      wr_req = 2'b01; wr_addr = {3'd0, 3'd3}; wr_data = {8'h00, 8'h77};
      rd_req = 2'b01; rd_addr = {3'd0, 3'd3};
      #2;
      chk("raw_wr_gnt", 32'(wr_gnt), 32'd1);
      chk("raw_rd_gnt", 32'(rd_gnt), 32'd1);
      @(negedge clk);
      wr_req = '0; rd_req = '0;
      #2;
      chk("raw_rd_valid", 32'(rd_valid), 32'd1);
`ifdef WR_FWD_EN
      chk("raw_rd_data", 32'(rd_data), 32'h77);
`else
      chk("raw_rd_data", 32'(rd_data), 32'hA5);
`endif
      @(negedge clk);
      rd_req = 2'b01;
      @(negedge clk);
      rd_req = '0;
      #2;
      chk("raw_reread", 32'(rd_data), 32'h77);

      // Mid-flight reset: rd_ptr is 1, so requester 0 wins after a scan wrap.
      @(negedge clk);
      rd_req = 2'b01;
      #2;
      chk("mf_rd_gnt", 32'(rd_gnt), 32'd1);
      @(negedge clk);
      rst = 1'b1; wr_req = '1; rd_req = '1;
      #2;
      chk("mf_rst_wr_gnt", 32'(wr_gnt), 32'd0);
      chk("mf_rst_rd_gnt", 32'(rd_gnt), 32'd0);
      @(negedge clk);
      #2;
      chk("mf_rd_valid", 32'(rd_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #2;
      chk("mf_wr_ptr0", 32'(wr_gnt), 32'd1);
      chk("mf_rd_ptr0", 32'(rd_gnt), 32'd1);
      chk("mf_rd_valid2", 32'(rd_valid), 32'd0);

      // Clean reset before the random phase so the model starts from known state.
      @(negedge clk);
      rst = 1'b1; wr_req = '0; rd_req = '0;
      @(negedge clk);
      @(negedge clk);
      for (int a = 0; a < DEPTH; a++) shadow[a] = mem[a];
      m_wptr = 0; m_rptr = 0; m_rv = 1'b0; m_rid = '0; m_rdata = '0;

      for (int c = 0; c < 600; c++) begin
         if (c > 0) @(negedge clk);
         rst     = ($urandom_range(31, 0) == 0);
         wr_req  = NREQ'($urandom);
         rd_req  = NREQ'($urandom);
         wr_addr = (NREQ*AW)'($urandom);
         rd_addr = (NREQ*AW)'($urandom);
         wr_data = (NREQ*WIDTH)'($urandom);
         #2;
         chk("rnd_rd_valid", 32'(rd_valid), 32'(m_rv));
         if (m_rv) begin
            chk("rnd_rd_id", 32'(rd_id), 32'(m_rid));
            chk("rnd_rd_data", 32'(rd_data), 32'(m_rdata));
         end
         wi = rst ? -1 : arb(wr_req, m_wptr);
         ri = rst ? -1 : arb(rd_req, m_rptr);
         e_wg = '0; e_rg = '0;
         if (wi >= 0) e_wg[wi] = 1'b1;
         if (ri >= 0) e_rg[ri] = 1'b1;
         chk("rnd_wr_gnt", 32'(wr_gnt), 32'(e_wg));
         chk("rnd_rd_gnt", 32'(rd_gnt), 32'(e_rg));
         chk("rnd_ram_we", 32'(ram_we), 32'(wi >= 0));
         chk("rnd_ram_re", 32'(ram_re), 32'(ri >= 0));
         if (wi >= 0) begin
            wa = wr_addr[wi*AW +: AW];
            wd = wr_data[wi*WIDTH +: WIDTH];
            chk("rnd_ram_wr_addr", 32'(ram_wr_addr), 32'(wa));
            chk("rnd_ram_din", 32'(ram_din), 32'(wd));
         end
         if (ri >= 0) begin
            ra = rd_addr[ri*AW +: AW];
            chk("rnd_ram_rd_addr", 32'(ram_rd_addr), 32'(ra));
         end

         // Advance the model by one clock.
         if (rst) begin
            m_wptr = 0; m_rptr = 0; m_rv = 1'b0; m_rid = '0;
         end else begin
            m_rv = (ri >= 0);
            if (ri >= 0) begin
               m_rid   = IW'(ri);
               m_rdata = shadow[ra];
`ifdef WR_FWD_EN
               if (wi >= 0 && wa == ra) m_rdata = wd;
`endif
               m_rptr = (ri + 1) % NREQ;
            end
            if (wi >= 0) begin
               shadow[wa] = wd;
               m_wptr = (wi + 1) % NREQ;
            end
         end
      end

      @(negedge clk);
      rst = 1'b0; wr_req = '0; rd_req = '0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
